// File: rtl/cr_iahbl_ibus_master_if.sv
// BMU ibus request/response and AHB-Lite IAHBL signals for the instruction-fetch master.
// master: the fetch master's view; slave: the BMU + AHB environment's view.
interface cr_iahbl_ibus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bmu_iahbl_ibus_req;
  logic [ADDR_W-1:0] bmu_iahbl_ibus_addr;
  logic [1:0]        bmu_iahbl_ibus_size;
  logic [3:0]        bmu_iahbl_ibus_prot;
  logic              bmu_iahbl_ibus_acc_deny;
  logic              iahbl_bmu_ibus_grnt;
  logic [DATA_W-1:0] iahbl_bmu_ibus_data;
  logic              iahbl_bmu_ibus_data_vld;
  logic              iahbl_bmu_ibus_trans_cmplt;
  logic              iahbl_bmu_ibus_acc_err;
  logic [ADDR_W-1:0] iahbl_haddr;
  logic [1:0]        iahbl_htrans;
  logic [2:0]        iahbl_hsize;
  logic [2:0]        iahbl_hburst;
  logic              iahbl_hwrite;
  logic [3:0]        iahbl_hprot;
  logic              iahbl_hready;
  logic              iahbl_hresp;
  logic [DATA_W-1:0] iahbl_hrdata;

  modport master (
    input  bmu_iahbl_ibus_req, bmu_iahbl_ibus_addr, bmu_iahbl_ibus_size,
           bmu_iahbl_ibus_prot, bmu_iahbl_ibus_acc_deny,
           iahbl_hready, iahbl_hresp, iahbl_hrdata,
    output iahbl_bmu_ibus_grnt, iahbl_bmu_ibus_data, iahbl_bmu_ibus_data_vld,
           iahbl_bmu_ibus_trans_cmplt, iahbl_bmu_ibus_acc_err,
           iahbl_haddr, iahbl_htrans, iahbl_hsize, iahbl_hburst, iahbl_hwrite, iahbl_hprot
  );

  modport slave (
    output bmu_iahbl_ibus_req, bmu_iahbl_ibus_addr, bmu_iahbl_ibus_size,
           bmu_iahbl_ibus_prot, bmu_iahbl_ibus_acc_deny,
           iahbl_hready, iahbl_hresp, iahbl_hrdata,
    input  iahbl_bmu_ibus_grnt, iahbl_bmu_ibus_data, iahbl_bmu_ibus_data_vld,
           iahbl_bmu_ibus_trans_cmplt, iahbl_bmu_ibus_acc_err,
           iahbl_haddr, iahbl_htrans, iahbl_hsize, iahbl_hburst, iahbl_hwrite, iahbl_hprot
  );
endinterface

// File: rtl/cr_iahbl_ibus_master.sv
// AHB-Lite single-beat instruction-fetch master, one outstanding transfer, pipelined address/data.
// Optional IAHBL_RSP_FF_EN registers the BMU response by one cycle.
module cr_iahbl_ibus_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  cr_iahbl_ibus_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, DATA, ERR1} state_t;

  state_t            state;
  logic              err_first;
  logic              addr_ok;
  logic              grnt;
  logic              issue;
  logic              data_vld_c;
  logic              acc_err_c;
  logic [DATA_W-1:0] data_c;

  // First ERROR cycle: the pipelined address must be cancelled (AHB two-cycle error).
  assign err_first  = (state == DATA) & bus.iahbl_hresp & ~bus.iahbl_hready;
  assign addr_ok    = ~cpurst & bus.bmu_iahbl_ibus_req & ~bus.bmu_iahbl_ibus_acc_deny & ~err_first;
  assign grnt       = ~cpurst & bus.bmu_iahbl_ibus_req & bus.iahbl_hready &
                      (bus.bmu_iahbl_ibus_acc_deny | addr_ok);
  assign issue      = grnt & addr_ok;

  assign bus.iahbl_bmu_ibus_grnt = grnt;
  assign bus.iahbl_htrans        = addr_ok ? 2'b10 : 2'b00;
  assign bus.iahbl_haddr         = ADDR_W'(bus.bmu_iahbl_ibus_addr);
  assign bus.iahbl_hsize         = {1'b0, bus.bmu_iahbl_ibus_size};
  assign bus.iahbl_hprot         = bus.bmu_iahbl_ibus_prot;
  assign bus.iahbl_hburst        = 3'b000;
  assign bus.iahbl_hwrite        = 1'b0;

  // hresp&hready seen straight from DATA is a slave protocol slip; still closed as an error.
  assign data_vld_c = ~cpurst & (state == DATA) & bus.iahbl_hready & ~bus.iahbl_hresp;
  assign acc_err_c  = ~cpurst & bus.iahbl_hready &
                      ((state == ERR1) | ((state == DATA) & bus.iahbl_hresp));
  assign data_c     = bus.iahbl_hrdata & {DATA_W{data_vld_c}};

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= IDLE;
    end else if (bus.iahbl_hready) begin
      state <= issue ? DATA : IDLE;
    end else if (err_first) begin
      state <= ERR1;
    end
  end

`ifdef IAHBL_RSP_FF_EN
  logic              data_vld_q;
  logic              acc_err_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      data_vld_q <= 1'b0;
      acc_err_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      data_vld_q <= data_vld_c;
      acc_err_q  <= acc_err_c;
      data_q     <= data_c;
    end
  end

  assign bus.iahbl_bmu_ibus_data_vld    = data_vld_q;
  assign bus.iahbl_bmu_ibus_acc_err     = acc_err_q;
  assign bus.iahbl_bmu_ibus_trans_cmplt = data_vld_q | acc_err_q;
  assign bus.iahbl_bmu_ibus_data        = data_q;
`else
  assign bus.iahbl_bmu_ibus_data_vld    = data_vld_c;
  assign bus.iahbl_bmu_ibus_acc_err     = acc_err_c;
  assign bus.iahbl_bmu_ibus_trans_cmplt = data_vld_c | acc_err_c;
  assign bus.iahbl_bmu_ibus_data        = data_c;
`endif
endmodule

// File: tb/tb_cr_iahbl_ibus_master.sv
// Directed-vector bench for the IAHBL fetch master; expected responses are written at
// zero-wait timing and shifted one cycle when IAHBL_RSP_FF_EN is defined.
module tb_cr_iahbl_ibus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  logic        pv = 1'b0, pe = 1'b0;
  logic [31:0] pd = '0;

  always #5 clk = ~clk;

  cr_iahbl_ibus_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  cr_iahbl_ibus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus_if.master)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, check at negedge, advance past the next posedge.
  task automatic cyc(input string tag, input logic req, input logic [31:0] addr,
                     input logic deny, input logic rdy, input logic resp,
                     input logic [31:0] rdata, input logic eg, input logic [1:0] eht,
                     input logic ev, input logic ee, input logic [31:0] ed);
    logic        cv, ce;
    logic [31:0] cd;
    bus_if.bmu_iahbl_ibus_req      = req;
    bus_if.bmu_iahbl_ibus_addr     = addr;
    bus_if.bmu_iahbl_ibus_acc_deny = deny;
    bus_if.iahbl_hready            = rdy;
    bus_if.iahbl_hresp             = resp;
    bus_if.iahbl_hrdata            = rdata;
    @(negedge clk);
`ifdef IAHBL_RSP_FF_EN
    cv = pv; ce = pe; cd = pd;
`else
    cv = ev; ce = ee; cd = ed;
`endif
    chk({tag, "_grnt"},   32'(bus_if.iahbl_bmu_ibus_grnt), 32'(eg));
    chk({tag, "_htrans"}, 32'(bus_if.iahbl_htrans), 32'(eht));
    if (eht == 2'b10) chk({tag, "_haddr"}, bus_if.iahbl_haddr, addr);
    chk({tag, "_vld"},    32'(bus_if.iahbl_bmu_ibus_data_vld), 32'(cv));
    chk({tag, "_err"},    32'(bus_if.iahbl_bmu_ibus_acc_err), 32'(ce));
    chk({tag, "_cmplt"},  32'(bus_if.iahbl_bmu_ibus_trans_cmplt), 32'(cv | ce));
    chk({tag, "_data"},   bus_if.iahbl_bmu_ibus_data, cd);
    pv = ev; pe = ee; pd = ed;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.bmu_iahbl_ibus_size = 2'b10;
    bus_if.bmu_iahbl_ibus_prot = 4'b1011;
    rst = 1'b1;
    // Reset with a live request: nothing granted, no bus transfer, no response.
    cyc("rst0", 1, 32'h0000_0100, 0, 1, 0, 32'hAAAA_AAAA, 0, 2'b00, 0, 0, 0);
    cyc("rst1", 1, 32'h0000_0100, 0, 1, 0, 32'hAAAA_AAAA, 0, 2'b00, 0, 0, 0);
    rst = 1'b0;

    // 1: single fetch, zero wait
    bus_if.bmu_iahbl_ibus_req = 1'b1; bus_if.bmu_iahbl_ibus_addr = 32'h100;
    bus_if.bmu_iahbl_ibus_acc_deny = 1'b0; bus_if.iahbl_hready = 1'b1;
    #1;
    chk("t1_hsize",  32'(bus_if.iahbl_hsize), 32'h2);
    chk("t1_hprot",  32'(bus_if.iahbl_hprot), 32'hB);
    chk("t1_hburst", 32'(bus_if.iahbl_hburst), 32'h0);
    chk("t1_hwrite", 32'(bus_if.iahbl_hwrite), 32'h0);
    cyc("t1a", 1, 32'h100, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    cyc("t1b", 0, 32'h0,   0, 1, 0, 32'hDEAD_BEEF, 0, 2'b00, 1, 0, 32'hDEAD_BEEF);
    cyc("t1c", 0, 32'h0,   0, 1, 0, 32'hDEAD_BEEF, 0, 2'b00, 0, 0, 0);

    // 2: back-to-back, no bubble
    cyc("t2a", 1, 32'h100, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    cyc("t2b", 1, 32'h104, 0, 1, 0, 32'h1111_1111, 1, 2'b10, 1, 0, 32'h1111_1111);
    cyc("t2c", 0, 32'h0,   0, 1, 0, 32'h2222_2222, 0, 2'b00, 1, 0, 32'h2222_2222);

    // 3: three wait states with N+1 pending
    cyc("t3a", 1, 32'h100, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    cyc("t3b", 1, 32'h104, 0, 0, 0, 32'h9999_9999, 0, 2'b10, 0, 0, 0);
    cyc("t3c", 1, 32'h104, 0, 0, 0, 32'h9999_9999, 0, 2'b10, 0, 0, 0);
    cyc("t3d", 1, 32'h104, 0, 0, 0, 32'h9999_9999, 0, 2'b10, 0, 0, 0);
    cyc("t3e", 1, 32'h104, 0, 1, 0, 32'h3333_3333, 1, 2'b10, 1, 0, 32'h3333_3333);
    cyc("t3f", 0, 32'h0,   0, 1, 0, 32'h4444_4444, 0, 2'b00, 1, 0, 32'h4444_4444);

    // 4: two-cycle ERROR; pending request cancelled in first error cycle
    cyc("t4a", 1, 32'h200, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    cyc("t4b", 1, 32'h204, 0, 0, 1, 32'h5555_5555, 0, 2'b00, 0, 0, 0);
    cyc("t4c", 0, 32'h0,   0, 1, 1, 32'h5555_5555, 0, 2'b00, 0, 1, 0);
    cyc("t4d", 0, 32'h0,   0, 1, 0, 32'h5555_5555, 0, 2'b00, 0, 0, 0);

    // 5: PMP-denied request granted without a bus transfer
    cyc("t5a", 1, 32'h300, 1, 1, 0, 32'h0,         1, 2'b00, 0, 0, 0);
    cyc("t5b", 0, 32'h0,   0, 1, 0, 32'h6666_6666, 0, 2'b00, 0, 0, 0);

    // 6: reset during a stalled data phase drops it
    cyc("t6a", 1, 32'h400, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    rst = 1'b1;
    cyc("t6b", 1, 32'h404, 0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 0);
    rst = 1'b0;
    cyc("t6c", 0, 32'h0,   0, 1, 0, 32'h6666_6666, 0, 2'b00, 0, 0, 0);
    cyc("t6d", 0, 32'h0,   0, 1, 0, 32'h6666_6666, 0, 2'b00, 0, 0, 0);

    // 7: new grant alongside error completion, then its OKAY beat
    cyc("t7a", 1, 32'h500, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    cyc("t7b", 0, 32'h0,   0, 0, 1, 32'h0,         0, 2'b00, 0, 0, 0);
    cyc("t7c", 1, 32'h508, 0, 1, 1, 32'h0,         1, 2'b10, 0, 1, 0);
    cyc("t7d", 0, 32'h0,   0, 1, 0, 32'h7777_7777, 0, 2'b00, 1, 0, 32'h7777_7777);

    // 8: single-cycle ERROR from a misbehaving slave still completes as error
    cyc("t8a", 1, 32'h600, 0, 1, 0, 32'h0,         1, 2'b10, 0, 0, 0);
    cyc("t8b", 0, 32'h0,   0, 1, 1, 32'h8888_8888, 0, 2'b00, 0, 1, 0);
    cyc("t8c", 0, 32'h0,   0, 1, 0, 32'h8888_8888, 0, 2'b00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
